// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one adjust+shift step per clock.
// Valid/ready on both sides; optional signed input, overflow saturation and leading-zero blanking.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_sign,
  output logic                out_overflow,
  output logic [DIGITS-1:0]   out_blank,
  output logic                busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic             ovf_q;
  logic             sign_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_fire;
  logic             out_fire;
  logic             last_step;
  logic             neg;
  logic [BIN_W-1:0] mag;
  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] bcd_shift;
  logic [BIN_W-1:0] bin_shift;
  logic             ovf_shift;
  logic             sat;
  logic [BCD_W-1:0] final_bcd;
  logic [DIGITS-1:0] final_blank;
  logic             zero_above;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_step = (state_q == SHIFT) && (cnt_q == CNT_W'(1));

  // Magnitude is kept unsigned, so -2^(BIN_W-1) negates to itself and reads as 2^(BIN_W-1).
  assign neg = (SIGNED != 0) && in_data[BIN_W-1];
  assign mag = neg ? (~in_data + BIN_W'(1)) : in_data;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_fire) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // One double-dabble step: add 3 to each digit >= 5, then shift {ovf, bcd, bin} left.
  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    bcd_shift = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
    bin_shift = {bin_q[BIN_W-2:0], 1'b0};
    ovf_shift = ovf_q | adj[BCD_W-1];
    sat       = ovf_shift | (bcd_shift[BCD_W-1 -: 4] > 4'd9);
    final_bcd = sat ? {DIGITS{4'h9}} : bcd_shift;
  end

  // Blank a digit when it and every digit above it are zero; digit 0 is always shown.
  always_comb begin
    final_blank = '0;
    zero_above  = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      zero_above     = zero_above & (final_bcd[4*d +: 4] == 4'd0);
      final_blank[d] = zero_above;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so an aborted conversion leaves nothing behind.
    if (!rst_n) begin
      bin_q        <= '0;
      bcd_q        <= '0;
      ovf_q        <= 1'b0;
      sign_q       <= 1'b0;
      cnt_q        <= '0;
      out_bcd      <= '0;
      out_sign     <= 1'b0;
      out_overflow <= 1'b0;
      out_blank    <= BLANK_RST;
    end else if (in_fire) begin
      bin_q  <= mag;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      sign_q <= neg;
      cnt_q  <= CNT_W'(BIN_W);
    end else if (state_q == SHIFT) begin
      bin_q <= bin_shift;
      bcd_q <= bcd_shift;
      ovf_q <= ovf_shift;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_step) begin
        out_bcd      <= final_bcd;
        out_sign     <= sign_q;
        out_overflow <= sat;
        out_blank    <= final_blank;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: four parameterisations, directed vectors with
// hand-computed results queued at issue time and checked by an independent monitor.
module tb_bin_to_bcd_seq;

  localparam int BUDGET = 200;

  typedef struct {
    int          dut;
    logic [19:0] bcd;
    logic        sign;
    logic        ovf;
    logic [4:0]  blank;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [4];
  logic [15:0] in_data   [4];
  logic        out_ready [4];
  logic        iready    [4];
  logic        ovalid    [4];
  logic        obusy     [4];
  logic        osign     [4];
  logic        oovf      [4];
  logic [19:0] obcd      [4];
  logic [4:0]  oblank    [4];

  logic [11:0] bcd_a;
  logic [2:0]  blank_a;
  logic [19:0] bcd_d, bcd_s;
  logic [4:0]  blank_d, blank_s;
  logic [15:0] bcd_f;
  logic [3:0]  blank_f;

  assign obcd[0]   = {8'h00, bcd_a};
  assign oblank[0] = {2'b00, blank_a};
  assign obcd[1]   = bcd_d;
  assign oblank[1] = blank_d;
  assign obcd[2]   = bcd_s;
  assign oblank[2] = blank_s;
  assign obcd[3]   = {4'h0, bcd_f};
  assign oblank[3] = {1'b0, blank_f};

  logic [4:0] blank_rst [4] = '{5'b00110, 5'b11110, 5'b11110, 5'b01110};

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(iready[0]),
    .in_data(in_data[0][7:0]), .out_valid(ovalid[0]), .out_ready(out_ready[0]),
    .out_bcd(bcd_a), .out_sign(osign[0]), .out_overflow(oovf[0]),
    .out_blank(blank_a), .busy(obusy[0]));

  bin_to_bcd_seq u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(iready[1]),
    .in_data(in_data[1]), .out_valid(ovalid[1]), .out_ready(out_ready[1]),
    .out_bcd(bcd_d), .out_sign(osign[1]), .out_overflow(oovf[1]),
    .out_blank(blank_d), .busy(obusy[1]));

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(iready[2]),
    .in_data(in_data[2]), .out_valid(ovalid[2]), .out_ready(out_ready[2]),
    .out_bcd(bcd_s), .out_sign(osign[2]), .out_overflow(oovf[2]),
    .out_blank(blank_s), .busy(obusy[2]));

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED(0)) u_f (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(iready[3]),
    .in_data(in_data[3]), .out_valid(ovalid[3]), .out_ready(out_ready[3]),
    .out_bcd(bcd_f), .out_sign(osign[3]), .out_overflow(oovf[3]),
    .out_blank(blank_f), .busy(obusy[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int d, input logic [19:0] b, input logic s,
                              input logic o, input logic [4:0] bl);
    exp_t e;
    e.dut = d; e.bcd = b; e.sign = s; e.ovf = o; e.blank = bl;
    return e;
  endfunction

  // Queue the expectation (unless the result is meant to be discarded), then handshake.
  task automatic send(input int d, input logic [15:0] v, input exp_t e, input bit push);
    int t;
    if (push) sbq.push_back(e);
    in_data[d]  = v;
    in_valid[d] = 1'b1;
    t = 0;
    while (!iready[d] && t < BUDGET) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= BUDGET) check($sformatf("dut%0d accept timeout in_ready", d), iready[d], 1'b1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while (!iready[d] && t < BUDGET) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= BUDGET) check($sformatf("dut%0d idle timeout in_ready", d), iready[d], 1'b1);
  endtask

  task automatic chk_reset(input int d);
    check($sformatf("dut%0d rst busy", d),      obusy[d],  1'b0);
    check($sformatf("dut%0d rst in_ready", d),  iready[d], 1'b1);
    check($sformatf("dut%0d rst out_valid", d), ovalid[d], 1'b0);
    check($sformatf("dut%0d rst bcd", d),       obcd[d],   20'h0);
    check($sformatf("dut%0d rst sign", d),      osign[d],  1'b0);
    check($sformatf("dut%0d rst ovf", d),       oovf[d],   1'b0);
    check($sformatf("dut%0d rst blank", d),     oblank[d], blank_rst[d]);
  endtask

  // Monitor: every accepted result is matched against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (ovalid[i] && out_ready[i]) begin
          if (sbq.size() == 0) begin
            check($sformatf("dut%0d unexpected out_valid", i), ovalid[i], 1'b0);
          end else begin
            mon_e = sbq.pop_front();
            check($sformatf("dut%0d result source", i), i, mon_e.dut);
            check($sformatf("dut%0d bcd", i),   obcd[i],   mon_e.bcd);
            check($sformatf("dut%0d sign", i),  osign[i],  mon_e.sign);
            check($sformatf("dut%0d ovf", i),   oovf[i],   mon_e.ovf);
            check($sformatf("dut%0d blank", i), oblank[i], mon_e.blank);
          end
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no completion, expected finish within 20000 cycles");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [19:0] snap;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk_reset(i);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8-bit / 3 digits: value and exact latency from accept to out_valid.
    send(0, 16'd255, mk(0, 20'h00255, 1'b0, 1'b0, 5'b00000), 1'b1);
    n = 0;
    while (!ovalid[0] && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    check("dut0 latency edges", n, 8);
    wait_idle(0);
    send(0, 16'd99, mk(0, 20'h00099, 1'b0, 1'b0, 5'b00100), 1'b1);
    wait_idle(0);

    // Defaults: full-scale and zero.
    send(1, 16'hFFFF, mk(1, 20'h65535, 1'b0, 1'b0, 5'b00000), 1'b1);
    wait_idle(1);
    send(1, 16'h0000, mk(1, 20'h00000, 1'b0, 1'b0, 5'b11110), 1'b1);
    wait_idle(1);

    // Signed: most negative, -1, zero, most positive.
    send(2, 16'h8000, mk(2, 20'h32768, 1'b1, 1'b0, 5'b00000), 1'b1);
    wait_idle(2);
    send(2, 16'hFFFF, mk(2, 20'h00001, 1'b1, 1'b0, 5'b11110), 1'b1);
    wait_idle(2);
    send(2, 16'h0000, mk(2, 20'h00000, 1'b0, 1'b0, 5'b11110), 1'b1);
    wait_idle(2);
    send(2, 16'h7FFF, mk(2, 20'h32767, 1'b0, 1'b0, 5'b00000), 1'b1);
    wait_idle(2);

    // Four digits: saturation above 9999, exact 9999, and the 10000 boundary.
    send(3, 16'd12345, mk(3, 20'h09999, 1'b0, 1'b1, 5'b00000), 1'b1);
    wait_idle(3);
    send(3, 16'd9999, mk(3, 20'h09999, 1'b0, 1'b0, 5'b00000), 1'b1);
    wait_idle(3);
    send(3, 16'd10000, mk(3, 20'h09999, 1'b0, 1'b1, 5'b00000), 1'b1);
    wait_idle(3);

    // Backpressure: result held, new input ignored, then back-to-back conversions.
    out_ready[1] = 1'b0;
    send(1, 16'd1234, mk(1, 20'h01234, 1'b0, 1'b0, 5'b10000), 1'b1);
    n = 0;
    while (!ovalid[1] && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    snap = 20'h01234;
    in_data[1]  = 16'd999;
    in_valid[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold c%0d out_valid", c), ovalid[1], 1'b1);
      check($sformatf("hold c%0d in_ready", c),  iready[1], 1'b0);
      check($sformatf("hold c%0d bcd", c),       obcd[1],   snap);
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    send(1, 16'd42, mk(1, 20'h00042, 1'b0, 1'b0, 5'b11100), 1'b1);
    send(1, 16'd7,  mk(1, 20'h00007, 1'b0, 1'b0, 5'b11110), 1'b1);
    wait_idle(1);

    // Reset in the middle of a conversion discards it.
    send(1, 16'd5000, mk(1, 20'h05000, 1'b0, 1'b0, 5'b10000), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mid-shift busy before reset", obusy[1], 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(1, 16'd100, mk(1, 20'h00100, 1'b0, 1'b0, 5'b11000), 1'b1);
    wait_idle(1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
